// File: rtl/regfile_arbiter_pkg.sv
// rtl/regfile_arbiter_pkg.sv - shared sizing defaults and client indices for the arbitrated register file
package regfile_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 4;

    // Index width for a power-of-two entry count.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEFAULT_ADDR_W = addr_w(DEFAULT_DEPTH);

    localparam logic CLIENT_0 = 1'b0;
    localparam logic CLIENT_1 = 1'b1;

endpackage

// File: rtl/regfile_core.sv
// rtl/regfile_core.sv - DEPTH x WIDTH storage, one combinational read port and one write port
module regfile_core #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read is combinational so a read granted right after a write sees the new value.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-client round-robin arbiter in front of a single-port register file
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_0_valid,
    output logic              req_0_ready,
    input  logic              req_0_write,
    input  logic [ADDR_W-1:0] req_0_addr,
    input  logic [WIDTH-1:0]  req_0_data,
    output logic              resp_0_valid,
    output logic [WIDTH-1:0]  resp_0_data,
    output logic              resp_0_write,
    input  logic              req_1_valid,
    output logic              req_1_ready,
    input  logic              req_1_write,
    input  logic [ADDR_W-1:0] req_1_addr,
    input  logic [WIDTH-1:0]  req_1_data,
    output logic              resp_1_valid,
    output logic [WIDTH-1:0]  resp_1_data,
    output logic              resp_1_write
);

    logic              ptr_q, ptr_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic              resp_write_q, resp_write_d;
    logic [WIDTH-1:0]  resp_data_q, resp_data_d;

    logic              grant_0, grant_1, grant_any;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  rdata;

    assign grant_0 = !RESET && req_0_valid && (!req_1_valid || ptr_q == CLIENT_0);
    assign grant_1 = !RESET && req_1_valid && (!req_0_valid || ptr_q == CLIENT_1);
    assign grant_any = grant_0 || grant_1;

    assign req_0_ready = grant_0;
    assign req_1_ready = grant_1;

    assign sel_write = grant_1 ? req_1_write : req_0_write;
    assign sel_addr  = grant_1 ? req_1_addr  : req_0_addr;
    assign sel_data  = grant_1 ? req_1_data  : req_0_data;

    regfile_core #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .we_i    (grant_any && sel_write),
        .waddr_i (sel_addr),
        .wdata_i (sel_data),
        .raddr_i (sel_addr),
        .rdata_o (rdata)
    );

    always_comb begin
        ptr_d        = ptr_q;
        resp_valid_d = {grant_1, grant_0};
        resp_write_d = grant_any && sel_write;
        resp_data_d  = '0;
        if (grant_0) begin
            ptr_d = CLIENT_1;
        end else if (grant_1) begin
            ptr_d = CLIENT_0;
        end
        if (grant_any && !sel_write) begin
            resp_data_d = rdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_q        <= CLIENT_0;
            resp_valid_q <= '0;
            resp_write_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_write_q <= resp_write_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // A response registered just before RESET rises must not leak out during the reset cycle.
    assign resp_0_valid = resp_valid_q[0] && !RESET;
    assign resp_1_valid = resp_valid_q[1] && !RESET;
    assign resp_0_write = resp_0_valid && resp_write_q;
    assign resp_1_write = resp_1_valid && resp_write_q;
    assign resp_0_data  = resp_0_valid ? resp_data_q : '0;
    assign resp_1_data  = resp_1_valid ? resp_data_q : '0;

endmodule
